ttc_intr_lite24: RTL and testbench

TTC_INTR_LITE24 -- requirements
Module: ttc_intr_lite24

---
 rtl/ttc_intr_lite24.sv | 59 +++++
 tb/tb_ttc_intr_lite24.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/ttc_intr_lite24.sv
// Timer/counter interrupt collector: rising-edge capture of five level sources into
// sticky status and overrun bits, a writable enable mask, and a registered irq.
module ttc_intr_lite24 (
    input  logic        pclk24,
    input  logic        n_p_reset24,
    input  logic        interval_intr24,
    input  logic [3:1]  match_intr24,
    input  logic        overflow_intr24,
    input  logic [15:0] pwdata24,
    input  logic        intr_en_reg_sel24,
    input  logic        intr_status_rd24,
    output logic [4:0]  intr_en_reg_out24,
    output logic [9:0]  intr_status_out24,
    output logic        irq24
);

    logic [4:0] level;
    logic [4:0] prev;
    logic [4:0] evt;
    logic [4:0] status;
    logic [4:0] overrun;
    logic [4:0] enable;
    logic [4:0] status_next;
    logic [4:0] overrun_next;

    assign level = {overflow_intr24, match_intr24, interval_intr24};
    assign evt   = level & ~prev;

    // A clearing read loses to a coincident event for status, but always clears overrun.
    always_comb begin
        status_next  = status | evt;
        overrun_next = overrun | (evt & status);
        if (intr_status_rd24) begin
            status_next  = evt;
            overrun_next = '0;
        end
    end

    always_ff @(posedge pclk24 or negedge n_p_reset24) begin
        if (!n_p_reset24) begin
            prev    <= '0;
            status  <= '0;
            overrun <= '0;
            enable  <= '0;
            irq24   <= 1'b0;
        end else begin
            prev    <= level;
            status  <= status_next;
            overrun <= overrun_next;
            if (intr_en_reg_sel24)
                enable <= pwdata24[4:0];
            irq24   <= |(status & enable);
        end
    end

    assign intr_en_reg_out24 = enable;
    assign intr_status_out24 = {overrun, status};

endmodule

// File: tb/tb_ttc_intr_lite24.sv
// Directed bench for ttc_intr_lite24 with hand-computed expected values.
module tb_ttc_intr_lite24;

    logic        pclk24 = 1'b0;
    logic        n_p_reset24 = 1'b0;
    logic        interval_intr24 = 1'b0;
    logic [3:1]  match_intr24 = '0;
    logic        overflow_intr24 = 1'b0;
    logic [15:0] pwdata24 = '0;
    logic        intr_en_reg_sel24 = 1'b0;
    logic        intr_status_rd24 = 1'b0;
    logic [4:0]  intr_en_reg_out24;
    logic [9:0]  intr_status_out24;
    logic        irq24;

    int checks = 0;
    int failures = 0;

    ttc_intr_lite24 dut (
        .pclk24            (pclk24),
        .n_p_reset24       (n_p_reset24),
        .interval_intr24   (interval_intr24),
        .match_intr24      (match_intr24),
        .overflow_intr24   (overflow_intr24),
        .pwdata24          (pwdata24),
        .intr_en_reg_sel24 (intr_en_reg_sel24),
        .intr_status_rd24  (intr_status_rd24),
        .intr_en_reg_out24 (intr_en_reg_out24),
        .intr_status_out24 (intr_status_out24),
        .irq24             (irq24)
    );

    always #5 pclk24 = ~pclk24;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one edge; inputs set after this take effect at the next edge.
    task automatic tick();
        @(posedge pclk24);
        #1;
    endtask

    task automatic set_levels(input logic [4:0] v);
        {overflow_intr24, match_intr24, interval_intr24} = v;
    endtask

    task automatic write_en(input logic [4:0] v);
        pwdata24 = {11'h7A5, v};
        intr_en_reg_sel24 = 1'b1;
        tick();
        intr_en_reg_sel24 = 1'b0;
    endtask

    task automatic read_status();
        intr_status_rd24 = 1'b1;
        tick();
        intr_status_rd24 = 1'b0;
    endtask

    initial begin
        #12;
        check("reset_status", 16'(intr_status_out24), 16'h000);
        check("reset_en", 16'(intr_en_reg_out24), 16'h00);
        check("reset_irq", 16'(irq24), 16'h0);
        n_p_reset24 = 1'b1;
        tick();

        // Basic
        write_en(5'h01);
        check("basic_en", 16'(intr_en_reg_out24), 16'h01);
        set_levels(5'h01);
        tick();
        check("basic_status_n1", 16'(intr_status_out24), 16'h001);
        check("basic_irq_n1", 16'(irq24), 16'h0);
        tick();
        check("basic_irq_n2", 16'(irq24), 16'h1);
        for (int i = 0; i < 6; i++) tick();
        check("basic_single_event", 16'(intr_status_out24), 16'h001);
        set_levels(5'h00);
        intr_status_rd24 = 1'b1;
        #1;
        check("basic_preclear", 16'(intr_status_out24), 16'h001);
        tick();
        intr_status_rd24 = 1'b0;
        check("basic_cleared", 16'(intr_status_out24), 16'h000);
        tick();
        check("basic_irq_off", 16'(irq24), 16'h0);

        // Overrun
        write_en(5'h00);
        set_levels(5'h04); tick();
        set_levels(5'h00); tick();
        set_levels(5'h04); tick();
        set_levels(5'h00); tick();
        check("ovr_status", 16'(intr_status_out24), 16'h084);
        tick();
        check("ovr_irq_masked", 16'(irq24), 16'h0);
        write_en(5'h04);
        check("ovr_status_kept", 16'(intr_status_out24), 16'h084);
        tick();
        check("ovr_irq_enabled", 16'(irq24), 16'h1);

        // Collision
        read_status();
        write_en(5'h10);
        set_levels(5'h10); tick();
        set_levels(5'h00); tick();
        set_levels(5'h10); tick();
        set_levels(5'h00); tick();
        check("coll_pre", 16'(intr_status_out24), 16'h210);
        check("coll_irq_pre", 16'(irq24), 16'h1);
        set_levels(5'h10);
        read_status();
        check("coll_status", 16'(intr_status_out24), 16'h010);
        tick();
        check("coll_irq", 16'(irq24), 16'h1);
        set_levels(5'h00);
        read_status();
        tick();

        // Multiple sources
        write_en(5'h1F);
        set_levels(5'h1F); tick();
        check("multi_status", 16'(intr_status_out24), 16'h01F);
        tick();
        check("multi_irq", 16'(irq24), 16'h1);
        read_status();
        check("multi_cleared", 16'(intr_status_out24), 16'h000);
        tick();
        check("multi_irq_off", 16'(irq24), 16'h0);
        check("multi_no_retrigger", 16'(intr_status_out24), 16'h000);

        // Reset mid-operation
        set_levels(5'h00); tick();
        set_levels(5'h1F); tick();
        set_levels(5'h00); tick();
        set_levels(5'h1F); tick();
        check("rst_pre_status", 16'(intr_status_out24), 16'h3FF);
        tick();
        check("rst_pre_irq", 16'(irq24), 16'h1);
        #2 n_p_reset24 = 1'b0;
        #1;
        check("rst_async_status", 16'(intr_status_out24), 16'h000);
        check("rst_async_irq", 16'(irq24), 16'h0);
        check("rst_async_en", 16'(intr_en_reg_out24), 16'h00);
        tick();
        n_p_reset24 = 1'b1;
        tick();
        check("rst_first_edge", 16'(intr_status_out24), 16'h01F);
        tick();
        check("rst_status_held", 16'(intr_status_out24), 16'h01F);
        check("rst_irq_no_en", 16'(irq24), 16'h0);

        // Mask
        set_levels(5'h00);
        read_status();
        write_en(5'h02);
        set_levels(5'h02); tick();
        set_levels(5'h00); tick();
        check("mask_irq_on", 16'(irq24), 16'h1);
        write_en(5'h00);
        tick();
        check("mask_irq_off", 16'(irq24), 16'h0);
        check("mask_status", 16'(intr_status_out24), 16'h002);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
